// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator with latency-compensated
// pixel requests and a registered RGB565 display stage.
// Coordinates are issued PIX_LAT cycles ahead of the screen position so the
// pixel_data returned by the content controller lands on the matching pixel.
// PIX_LAT must stay within 1..H_SYNC+H_BACK so requests never cross a line.
module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned PIX_LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb,
    output logic        frame_start
);

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned AHD_W   = CNT_W + 1;
    localparam int unsigned RGB_W   = 16;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;
    localparam int unsigned H_END   = HA + H_DISP;
    localparam int unsigned V_END   = VA + V_DISP;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;
    logic             r_fs;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_v_act;
    logic             w_h_act;
    logic             w_de;
    logic             w_req;
    logic [AHD_W-1:0] w_h_ahead;

    // Counter decodes
    assign w_h_last = (r_h_cnt == CNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == CNT_W'(V_TOTAL - 1));
    assign w_v_act  = (r_v_cnt >= CNT_W'(VA)) && (r_v_cnt < CNT_W'(V_END));
    assign w_h_act  = (r_h_cnt >= CNT_W'(HA)) && (r_h_cnt < CNT_W'(H_END));
    assign w_de     = w_v_act && w_h_act;

    // Column the request targets: current position advanced by the pixel latency
    assign w_h_ahead = AHD_W'(r_h_cnt) + AHD_W'(PIX_LAT);
    assign w_req     = w_v_act && (w_h_ahead >= AHD_W'(HA)) && (w_h_ahead < AHD_W'(H_END));

    // Zero-latency coordinate requests decoded from the counters
    assign pixel_xpos = w_req   ? CNT_W'(w_h_ahead - AHD_W'(HA)) : '0;
    assign pixel_ypos = w_v_act ? (r_v_cnt - CNT_W'(VA))         : '0;

    // Horizontal / vertical raster counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Display stage: syncs, enable, blanked pixel and frame marker one cycle after the counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
            r_rgb <= '0;
            r_fs  <= 1'b0;
        end else begin
            r_hs  <= (r_h_cnt >= CNT_W'(H_SYNC));
            r_vs  <= (r_v_cnt >= CNT_W'(V_SYNC));
            r_de  <= w_de;
            r_rgb <= w_de ? pixel_data : '0;
            r_fs  <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_de      = r_de;
    assign vga_rgb     = r_rgb;
    assign frame_start = r_fs;

endmodule
